// File: rtl/fetch_seq_pkg.sv
// ----------------------------------------------------------------------------
// fetch_seq_pkg : shared types and default widths for the fetch sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_seq_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : clearable up-counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter
  import fetch_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next_o is the post-increment value, exposed so callers can act on it this cycle
  assign next_o = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer : launches a fetch run, supervises it, reports PC and length
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WDOG_MAX = 1000
) (
  input  logic              f_clk,
  input  logic              f_rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              clear,
  input  logic              halt_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              ack,
  output logic              start_o,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic              halt_o,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W-1:0] final_pc,
  output logic [CNT_W-1:0]  cycle_cnt
);

  seq_state_t        state_q;
  logic              ack_q;
  logic              start_q;
  logic              halt_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [ADDR_W-1:0] final_pc_q;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              wdog_hit;

  // Counter is zeroed on the edge into LAUNCH and counts every RUN cycle, the exit cycle included
  assign cnt_clr = (state_q == IDLE) && req;
  assign cnt_en  = (state_q == RUN);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk_i  (f_clk),
    .rst_ni (f_rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_q),
    .next_o (cnt_next)
  );

  generate
    if (WDOG_MAX != 0) begin : g_wdog
      assign wdog_hit = (64'(cnt_next) == 64'(WDOG_MAX));
    end else begin : g_no_wdog
      assign wdog_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge f_clk) begin
    if (!f_rst_n) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      start_q      <= 1'b0;
      halt_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_addr_q <= '0;
      final_pc_q   <= '0;
    end else begin
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q      <= LAUNCH;
            ack_q        <= 1'b1;
            start_q      <= 1'b1;
            start_addr_q <= req_addr;
            halt_q       <= 1'b0;
            busy_q       <= 1'b1;
            timeout_q    <= 1'b0;
          end
        end
        LAUNCH: begin
          state_q <= RUN;
        end
        RUN: begin
          // A decoded halt beats a simultaneous watchdog expiry
          if (halt_i || wdog_hit) begin
            state_q    <= DONE;
            final_pc_q <= pc_i;
            timeout_q  <= ~halt_i;
            halt_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        DONE: begin
          if (clear) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack          = ack_q;
  assign start_o      = start_q;
  assign start_addr_o = start_addr_q;
  assign halt_o       = halt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign final_pc     = final_pc_q;
  assign cycle_cnt    = cnt_q;

endmodule

`default_nettype wire
